// File: rtl/bmp280_fmt_pkg.sv
// Shared types and constants for the BMP280 UART line formatter.
`timescale 1ns/1ps
package bmp280_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  // Characters in one "T=... P=...<eol>" line.
  function automatic int line_len(input int temp_w, input int press_w, input bit crlf);
    return 2 + temp_w / 4 + 3 + press_w / 4 + (crlf ? 2 : 1);
  endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Converts one 4-bit value into its uppercase ASCII hex digit.
`timescale 1ns/1ps
module nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/bmp280_uart_formatter.sv
// Captures a BMP280 raw temperature/pressure pair and streams it to the UART
// transmitter as "T=xxxxx P=xxxxx\r\n", one byte per enable/ready handshake.
`timescale 1ns/1ps
module bmp280_uart_formatter
  import bmp280_fmt_pkg::*;
#(
  parameter int TEMP_W   = 20,
  parameter int PRESS_W  = 20,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               sample_valid,
  input  logic [TEMP_W-1:0]  temp_raw,
  input  logic [PRESS_W-1:0] press_raw,
  input  logic               tx_ready,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic               overrun
);

  localparam int TD    = TEMP_W / 4;
  localparam int PD    = PRESS_W / 4;
  localparam int L     = line_len(TEMP_W, PRESS_W, EOL_CRLF);
  localparam int IDX_W = $clog2(L);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(L - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [TEMP_W-1:0]  temp_q, temp_nxt;
  logic [PRESS_W-1:0] press_q, press_nxt;
  logic               tx_en_nxt, overrun_nxt;
  logic [7:0]         tx_data_nxt;

  int         pos;
  logic       hex_en;
  logic [3:0] nib;
  logic [7:0] lit, hex_ascii, char_sel;

  nibble_to_ascii u_hex (
    .nibble (nib),
    .ascii  (hex_ascii)
  );

  // Character for the current line position, built from the frozen captured words.
  always_comb begin
    pos    = int'(idx);
    hex_en = 1'b0;
    nib    = 4'h0;
    lit    = 8'h00;
    if (pos == 0)                     lit = CH_T;
    else if (pos == 1)                lit = CH_EQ;
    else if (pos < 2 + TD) begin
      hex_en = 1'b1;
      nib    = 4'(temp_q >> (4 * (TD + 1 - pos)));
    end
    else if (pos == 2 + TD)           lit = CH_SP;
    else if (pos == 3 + TD)           lit = CH_P;
    else if (pos == 4 + TD)           lit = CH_EQ;
    else if (pos < 5 + TD + PD) begin
      hex_en = 1'b1;
      nib    = 4'(press_q >> (4 * (4 + TD + PD - pos)));
    end
    else if (EOL_CRLF && pos == 5 + TD + PD) lit = CH_CR;
    else                              lit = CH_LF;
    char_sel = hex_en ? hex_ascii : lit;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      idx     <= '0;
      temp_q  <= '0;
      press_q <= '0;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      temp_q  <= temp_nxt;
      press_q <= press_nxt;
      tx_en   <= tx_en_nxt;
      tx_data <= tx_data_nxt;
      overrun <= overrun_nxt;
    end
  end

  // WAIT_ACK waits for ready to drop so the lingering post-accept ready is never
  // mistaken for the transmitter being free again.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    temp_nxt    = temp_q;
    press_nxt   = press_q;
    tx_en_nxt   = 1'b0;
    tx_data_nxt = tx_data;
    overrun_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          temp_nxt  = temp_raw;
          press_nxt = press_raw;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_en_nxt   = 1'b1;
          tx_data_nxt = char_sel;
          state_nxt   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!tx_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if (idx == LAST) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (sample_valid && state != IDLE) overrun_nxt = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bmp280_uart_formatter.sv
// Self-checking bench: formatter driven into a behavioural UART transmitter,
// received bytes compared against a line model and fixed vector tables.
`timescale 1ns/1ps
module tb_bmp280_uart_formatter;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        n_rst;
  logic        sample_valid, sample_valid_lf, hold_low;
  logic [19:0] temp_raw, press_raw;
  logic        tx_ready, tx_en, busy, overrun;
  logic [7:0]  tx_data;
  logic        tx_ready_lf, tx_en_lf, busy_lf, overrun_lf;
  logic [7:0]  tx_data_lf;

  int errors = 0;
  int checks = 0;
  int ovr_cnt = 0;
  byte_q_t got, got_lf;
  logic prev_en = 1'b0, prev_ovr = 1'b0;

  int cnt0, cnt1;
  logic ack0, ack1;

  always #5 clk = ~clk;

  bmp280_uart_formatter #(.TEMP_W(20), .PRESS_W(20), .EOL_CRLF(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .sample_valid(sample_valid),
    .temp_raw(temp_raw), .press_raw(press_raw), .tx_ready(tx_ready),
    .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .overrun(overrun)
  );

  bmp280_uart_formatter #(.TEMP_W(20), .PRESS_W(20), .EOL_CRLF(1'b0)) dut_lf (
    .clk(clk), .n_rst(n_rst), .sample_valid(sample_valid_lf),
    .temp_raw(temp_raw), .press_raw(press_raw), .tx_ready(tx_ready_lf),
    .tx_en(tx_en_lf), .tx_data(tx_data_lf), .busy(busy_lf), .overrun(overrun_lf)
  );

  // Transmitter model: ready stays high one cycle after accepting, then busy 1-4 cycles.
  assign tx_ready    = !hold_low && (cnt0 == 0);
  assign tx_ready_lf = (cnt1 == 0);

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt0 <= 0; ack0 <= 1'b0; cnt1 <= 0; ack1 <= 1'b0;
    end else begin
      if (tx_en && tx_ready) ack0 <= 1'b1;
      else if (ack0) begin ack0 <= 1'b0; cnt0 <= int'($urandom_range(1, 4)); end
      else if (cnt0 != 0) cnt0 <= cnt0 - 1;
      if (tx_en_lf && tx_ready_lf) ack1 <= 1'b1;
      else if (ack1) begin ack1 <= 1'b0; cnt1 <= int'($urandom_range(1, 4)); end
      else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    end
  end

  always @(negedge clk) begin
    if (tx_en) begin
      got.push_back(tx_data);
      checks++;
      if (prev_en) begin errors++; $display("[TB] FAIL tx_en_width: high 2+ cycles, required 1"); end
    end
    if (overrun) begin
      ovr_cnt++;
      checks++;
      if (prev_ovr) begin errors++; $display("[TB] FAIL overrun_width: high 2+ cycles, required 1"); end
    end
    if (tx_en_lf) got_lf.push_back(tx_data_lf);
    prev_en  = tx_en;
    prev_ovr = overrun;
  end

  function automatic logic [7:0] hexc(input logic [3:0] v);
    if (v < 4'd10) return 8'(int'("0") + int'(v));
    return 8'(int'("A") + int'(v) - 10);
  endfunction

  function automatic byte_q_t build_line(input logic [19:0] t, input logic [19:0] p, input bit crlf);
    byte_q_t q;
    q.push_back("T"); q.push_back("=");
    for (int d = 4; d >= 0; d--) q.push_back(hexc(4'(t >> (4 * d))));
    q.push_back(" "); q.push_back("P"); q.push_back("=");
    for (int d = 4; d >= 0; d--) q.push_back(hexc(4'(p >> (4 * d))));
    if (crlf) q.push_back(8'd13);
    q.push_back(8'd10);
    return q;
  endfunction

  function automatic byte_q_t str_to_q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    return q;
  endfunction

  task automatic applyStimulus(input logic [19:0] t, input logic [19:0] p);
    @(negedge clk);
    temp_raw = t; press_raw = p; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    temp_raw = 20'($urandom); press_raw = 20'($urandom);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || busy_lf) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (busy || busy_lf) begin errors++; $display("[TB] FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n); end
  endtask

  task automatic waitBytes(input int n, input string name);
    int c = 0;
    while (got.size() < n && c < 3000) begin @(negedge clk); #1; c++; end
    checks++;
    if (got.size() < n) begin errors++; $display("[TB] FAIL %s_bytes_timeout: got %0d bytes, required %0d", name, got.size(), n); end
  endtask

  task automatic checkOutput(input string name, input byte_q_t exp, input int exp_ovr);
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("[TB] FAIL %s_len: got %0d bytes, required %0d", name, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("[TB] FAIL %s_byte%0d: got %h, required %h", name, i, got[i], exp[i]);
      end
    end
    checks++;
    if (ovr_cnt != exp_ovr) begin
      errors++; $display("[TB] FAIL %s_overrun: got %0d pulses, required %0d", name, ovr_cnt, exp_ovr);
    end
    got.delete();
    ovr_cnt = 0;
  endtask

  logic [19:0] tab_t [4];
  logic [19:0] tab_p [4];
  string       tab_s [4];

  initial begin
    logic [19:0] rt, rp, bt, bp;
    byte_q_t exp;
    int n_bad, c;

    tab_t[0] = 20'h8A3F1; tab_p[0] = 20'h5C0E2; tab_s[0] = "T=8A3F1 P=5C0E2\015\012";
    tab_t[1] = 20'h00000; tab_p[1] = 20'hFFFFF; tab_s[1] = "T=00000 P=FFFFF\015\012";
    tab_t[2] = 20'hABCDE; tab_p[2] = 20'h12345; tab_s[2] = "T=ABCDE P=12345\015\012";
    tab_t[3] = 20'hF0F0F; tab_p[3] = 20'h09A9B; tab_s[3] = "T=F0F0F P=09A9B\015\012";

    n_rst = 1'b0; sample_valid = 1'b0; sample_valid_lf = 1'b0; hold_low = 1'b0;
    temp_raw = '0; press_raw = '0;
    #22;
    checks += 4;
    if (tx_en !== 1'b0)      begin errors++; $display("[TB] FAIL rst_tx_en: got %b, required 0", tx_en); end
    if (tx_data !== 8'h00)   begin errors++; $display("[TB] FAIL rst_tx_data: got %h, required 00", tx_data); end
    if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
    if (overrun !== 1'b0)    begin errors++; $display("[TB] FAIL rst_overrun: got %b, required 0", overrun); end
    @(negedge clk); n_rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(tab_t[i], tab_p[i]);
      waitIdle($sformatf("tab%0d", i));
      repeat (2) @(negedge clk);
      checkOutput($sformatf("tab%0d", i), str_to_q(tab_s[i]), 0);
    end

    for (int i = 0; i < 6; i++) begin
      rt = 20'($urandom); rp = 20'($urandom);
      applyStimulus(rt, rp);
      waitIdle($sformatf("rnd%0d", i));
      repeat (2) @(negedge clk);
      checkOutput($sformatf("rnd%0d", i), build_line(rt, rp, 1'b1), 0);
    end

    got_lf.delete();
    @(negedge clk); temp_raw = 20'h00000; press_raw = 20'hFFFFF; sample_valid_lf = 1'b1;
    @(negedge clk); sample_valid_lf = 1'b0;
    waitIdle("lf");
    repeat (2) @(negedge clk);
    exp = str_to_q("T=00000 P=FFFFF\012");
    checks++;
    if (got_lf.size() != 16) begin errors++; $display("[TB] FAIL lf_len: got %0d bytes, required 16", got_lf.size()); end
    for (int i = 0; i < 16 && i < got_lf.size(); i++) begin
      checks++;
      if (got_lf[i] !== exp[i]) begin errors++; $display("[TB] FAIL lf_byte%0d: got %h, required %h", i, got_lf[i], exp[i]); end
    end
    got.delete(); ovr_cnt = 0;

    applyStimulus(20'h8A3F1, 20'h5C0E2);
    waitBytes(5, "ovr_mid");
    temp_raw = 20'h11111; press_raw = 20'h22222; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    waitBytes(17, "ovr_end");
    c = 0;
    while (tx_ready && c < 200) begin @(negedge clk); c++; end
    while (!tx_ready && c < 200) begin @(negedge clk); c++; end
    checks++;
    if (!busy) begin errors++; $display("[TB] FAIL ovr_final_wait: busy got 0, required 1"); end
    sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    waitIdle("ovr");
    repeat (20) @(negedge clk);
    checkOutput("ovr", build_line(20'h8A3F1, 20'h5C0E2, 1'b1), 2);

    hold_low = 1'b1;
    applyStimulus(20'h3C7A0, 20'hE1D29);
    n_bad = 0;
    repeat (50) begin @(negedge clk); if (tx_en) n_bad++; end
    checks++;
    if (n_bad != 0) begin errors++; $display("[TB] FAIL hold_no_tx: got %0d strobes, required 0", n_bad); end
    hold_low = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_en !== 1'b1) begin errors++; $display("[TB] FAIL hold_first_tx: tx_en got %b, required 1", tx_en); end
    waitIdle("hold");
    repeat (2) @(negedge clk);
    checkOutput("hold", build_line(20'h3C7A0, 20'hE1D29, 1'b1), 0);

    applyStimulus(20'h8A3F1, 20'h5C0E2);
    waitBytes(9, "rst");
    #1 n_rst = 1'b0;
    #1;
    checks += 3;
    if (tx_en !== 1'b0)   begin errors++; $display("[TB] FAIL rst_mid_tx_en: got %b, required 0", tx_en); end
    if (busy !== 1'b0)    begin errors++; $display("[TB] FAIL rst_mid_busy: got %b, required 0", busy); end
    if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_overrun: got %b, required 0", overrun); end
    repeat (4) @(negedge clk);
    checks++;
    if (got.size() != 9) begin errors++; $display("[TB] FAIL rst_mid_count: got %0d bytes, required 9", got.size()); end
    n_rst = 1'b1;
    got.delete(); ovr_cnt = 0;
    applyStimulus(20'h4B2E8, 20'h7F013);
    waitIdle("rst_after");
    repeat (2) @(negedge clk);
    checkOutput("rst_after", build_line(20'h4B2E8, 20'h7F013, 1'b1), 0);

    rt = 20'($urandom); rp = 20'($urandom);
    bt = 20'($urandom); bp = 20'($urandom);
    applyStimulus(rt, rp);
    waitIdle("b2b_first");
    temp_raw = bt; press_raw = bp; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    waitIdle("b2b_second");
    repeat (2) @(negedge clk);
    exp = build_line(rt, rp, 1'b1);
    exp = {exp, build_line(bt, bp, 1'b1)};
    checkOutput("b2b", exp, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
